// File: rtl/fft_bitrev_buf_pkg.sv
// Shared FFT helpers: packed complex word width, frame length and the
// bit-reversal permutation used to address the reorder banks.
package fft_bitrev_buf_pkg;

    localparam int max_log2n = 10;

    typedef logic [max_log2n-1:0] fft_addr_t;

    function automatic int dw_of(input int width);
        return 2 * width;
    endfunction

    function automatic int n_of(input int log2n);
        return 1 << log2n;
    endfunction

    // Reverses the low 'bits' bits of a; bits above 'bits' come back as zero.
    function automatic fft_addr_t bitrev(input fft_addr_t a, input int bits);
        fft_addr_t r;
        r = '0;
        for (int i = 0; i < max_log2n; i++) begin
            if (i < bits) begin
                r[i] = a[bits-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_buf_if.sv
// Valid/ready stream pair around the reorder buffer: natural-order samples in,
// bit-reversed samples out.
interface fft_bitrev_buf_if #(
    parameter int dw = 64
) ();
    logic          in_valid;
    logic          in_ready;
    logic [dw-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [dw-1:0] out_data;
    logic          out_last;

    // The buffer sinks the input stream and sources the output stream.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/fft_bitrev_bank.sv
// One N x dw sample bank: a single synchronous write port and an
// asynchronous read port, so the drained sample is visible in the same cycle.
module fft_bitrev_bank #(
    parameter int dw    = 64,
    parameter int log2n = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [log2n-1:0] waddr,
    input  logic [dw-1:0]    wdata,
    input  logic [log2n-1:0] raddr,
    output logic [dw-1:0]    rdata
);
    localparam int n = 1 << log2n;

    logic [dw-1:0] mem [n];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_bitrev_buf.sv
// Ping-pong bit-reversal reorder buffer feeding the first DIT butterfly stage;
// one bank fills in natural order while the other drains in bit-reversed order.
module fft_bitrev_buf
    import fft_bitrev_buf_pkg::*;
#(
    parameter int width = 32,
    parameter int log2n = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    fft_bitrev_buf_if.slave   bus
);
    localparam int dw = dw_of(width);
    localparam int n  = n_of(log2n);
    localparam logic [log2n-1:0] cnt_max = log2n'(n - 1);

    logic             wr_bank_reg, wr_bank_next;
    logic [log2n-1:0] wr_cnt_reg,  wr_cnt_next;
    logic             rd_bank_reg, rd_bank_next;
    logic [log2n-1:0] rd_cnt_reg,  rd_cnt_next;
    logic [1:0]       full_reg,    full_next;

    logic             in_ready;
    logic             out_valid;
    logic             in_hs;
    logic             out_hs;
    logic [log2n-1:0] rd_addr;
    logic [dw-1:0]    rd_word [2];

    // Ready/valid depend only on registered flags, never on the partner handshake.
    assign in_ready  = !full_reg[wr_bank_reg];
    assign out_valid = full_reg[rd_bank_reg];
    assign in_hs     = bus.in_valid && in_ready;
    assign out_hs    = out_valid && bus.out_ready;
    assign rd_addr   = log2n'(bitrev(fft_addr_t'(rd_cnt_reg), log2n));

    always_comb begin
        wr_bank_next = wr_bank_reg;
        wr_cnt_next  = wr_cnt_reg;
        rd_bank_next = rd_bank_reg;
        rd_cnt_next  = rd_cnt_reg;
        full_next    = full_reg;

        if (in_hs) begin
            if (wr_cnt_reg == cnt_max) begin
                full_next[wr_bank_reg] = 1'b1;
                wr_bank_next           = !wr_bank_reg;
                wr_cnt_next            = '0;
            end else begin
                wr_cnt_next = wr_cnt_reg + 1'b1;
            end
        end

        // Fill and drain always target different banks, so both updates stand.
        if (out_hs) begin
            if (rd_cnt_reg == cnt_max) begin
                full_next[rd_bank_reg] = 1'b0;
                rd_bank_next           = !rd_bank_reg;
                rd_cnt_next            = '0;
            end else begin
                rd_cnt_next = rd_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_reg <= 1'b0;
            wr_cnt_reg  <= '0;
            rd_bank_reg <= 1'b0;
            rd_cnt_reg  <= '0;
            full_reg    <= '0;
        end else begin
            wr_bank_reg <= wr_bank_next;
            wr_cnt_reg  <= wr_cnt_next;
            rd_bank_reg <= rd_bank_next;
            rd_cnt_reg  <= rd_cnt_next;
            full_reg    <= full_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            logic bank_we;
            assign bank_we = in_hs && (wr_bank_reg == 1'(gi));

            fft_bitrev_bank #(
                .dw    (dw),
                .log2n (log2n)
            ) u_bank (
                .clk   (clk),
                .we    (bank_we),
                .waddr (wr_cnt_reg),
                .wdata (bus.in_data),
                .raddr (rd_addr),
                .rdata (rd_word[gi])
            );
        end
    endgenerate

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? rd_word[rd_bank_reg] : '0;
    assign bus.out_last  = out_valid && (rd_cnt_reg == cnt_max);

endmodule

// File: tb/tb_fft_bitrev_buf.sv
// Directed bench for the bit-reversal reorder buffer: N=8 main instance with a
// bit-reversal scoreboard, plus small N=2 and N=16 instances checked against tables.
module tb_fft_bitrev_buf;

    logic clk;
    logic rst_n;

    fft_bitrev_buf_if #(.dw(64)) bus8  ();
    fft_bitrev_buf_if #(.dw(64)) bus2  ();
    fft_bitrev_buf_if #(.dw(64)) bus16 ();

    fft_bitrev_buf #(.width(32), .log2n(3)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    fft_bitrev_buf #(.width(32), .log2n(1)) dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
    fft_bitrev_buf #(.width(32), .log2n(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    bit rand_mode = 0;

    int tbl8  [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
    int tbl2  [2]  = '{0, 1};
    int tbl16 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    logic [63:0] exp_q [$];

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) bus8.out_ready = 1'($urandom_range(0, 1));
    endtask

    // Holds in_valid/in_data until the sample is accepted; returns stall cycles.
    task automatic send8(input logic [63:0] d, output int waits);
        logic hs;
        bus8.in_valid = 1'b1;
        bus8.in_data  = d;
        waits = 0;
        hs = 1'b0;
        while (!hs && waits <= 1000) begin
            @(negedge clk);
            hs = bus8.in_ready;
            tick();
            if (!hs) waits++;
        end
        if (!hs) check_vec("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain8();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        check_vec("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard/monitor for the N=8 instance.
    initial begin
        logic [63:0] fbuf [8];
        logic [63:0] prev_data;
        logic [63:0] e;
        logic        prev_last;
        bit          prev_stall;
        int          wcnt;
        int          out_idx;
        wcnt = 0; out_idx = 0; prev_stall = 0; prev_data = '0; prev_last = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wcnt = 0;
                out_idx = 0;
                prev_stall = 0;
                exp_q.delete();
            end else begin
                if (bus8.out_valid && prev_stall) begin
                    check_vec("hold_data", bus8.out_data, prev_data);
                    check_vec("hold_last", 64'(bus8.out_last), 64'(prev_last));
                end
                if (bus8.out_valid && bus8.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_vec("unexpected_out", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_vec("out_data", bus8.out_data, e);
                    end
                    check_vec("out_last", 64'(bus8.out_last), 64'(out_idx == 7));
                    out_idx = (out_idx + 1) % 8;
                end
                if (!bus8.out_valid) begin
                    check_vec("idle_zero", {bus8.out_data[62:0], bus8.out_last}, 64'd0);
                end
                prev_stall = bus8.out_valid && !bus8.out_ready;
                prev_data  = bus8.out_data;
                prev_last  = bus8.out_last;
                if (bus8.in_valid && bus8.in_ready) begin
                    fbuf[wcnt] = bus8.in_data;
                    wcnt++;
                    if (wcnt == 8) begin
                        for (int k = 0; k < 8; k++) exp_q.push_back(fbuf[tbl8[k]]);
                        wcnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0;
        bus8.in_valid = 0;  bus8.in_data = '0;  bus8.out_ready = 0;
        bus2.in_valid = 0;  bus2.in_data = '0;  bus2.out_ready = 0;
        bus16.in_valid = 0; bus16.in_data = '0; bus16.out_ready = 0;
        repeat (2) @(negedge clk);
        check_vec("rst_in_ready",  64'(bus8.in_ready),  64'd1);
        check_vec("rst_out_valid", 64'(bus8.out_valid), 64'd0);
        check_vec("rst_out_last",  64'(bus8.out_last),  64'd0);
        check_vec("rst_out_data",  bus8.out_data,       64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single frame, natural values 0..7.
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check_vec("lat_before", 64'(bus8.out_valid), 64'd0);
            send8(64'(i), w);
            check_vec("t1_no_stall", 64'(w), 64'd0);
        end
        bus8.in_valid = 1'b0;
        check_vec("lat_after", 64'(bus8.out_valid), 64'd1);
        drain8();

        // Four back-to-back frames at full rate.
        for (int c = 0; c <= 40; c++) begin
            bus8.in_valid = (c < 32);
            bus8.in_data  = 64'(c);
            @(negedge clk);
            if (c < 32) check_vec("stream_rdy", 64'(bus8.in_ready), 64'd1);
            check_vec("stream_valid", 64'(bus8.out_valid), 64'(c >= 8 && c <= 39));
            @(posedge clk); #1;
        end
        bus8.in_valid = 1'b0;
        check_vec("stream_sb", 64'(exp_q.size()), 64'd0);

        // Fill both banks with the output stalled.
        bus8.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send8(64'(i), w);
            check_vec("fill_no_stall", 64'(w), 64'd0);
        end
        bus8.in_valid = 1'b0;
        @(negedge clk);
        check_vec("full_in_ready", 64'(bus8.in_ready), 64'd0);
        check_vec("full_out_valid", 64'(bus8.out_valid), 64'd1);
        check_vec("full_out_data", bus8.out_data, 64'd0);
        @(posedge clk); #1;
        bus8.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_vec("drain_rdy_lo", 64'(bus8.in_ready), 64'd0);
        end
        @(negedge clk);
        check_vec("drain_rdy_hi", 64'(bus8.in_ready), 64'd1);
        @(posedge clk); #1;
        drain8();

        // Twenty frames with random input gaps and output stalls.
        rand_mode = 1;
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < 8; i++) begin
                bus8.in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
                send8({$urandom(), $urandom()}, w);
            end
        end
        bus8.in_valid = 1'b0;
        drain8();
        rand_mode = 0;
        bus8.out_ready = 1'b1;
        tick();

        // Asynchronous reset in the middle of a frame.
        bus8.out_ready = 1'b0;
        for (int i = 0; i < 13; i++) send8(64'h50 + 64'(i), w);
        bus8.in_valid = 1'b0;
        @(negedge clk);
        check_vec("pre_rst_valid", 64'(bus8.out_valid), 64'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_vec("arst_valid", 64'(bus8.out_valid), 64'd0);
        check_vec("arst_data",  bus8.out_data,       64'd0);
        check_vec("arst_last",  64'(bus8.out_last),  64'd0);
        check_vec("arst_ready", 64'(bus8.in_ready),  64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send8(64'h100 + 64'(i), w);
        bus8.in_valid = 1'b0;
        drain8();

        // N=2 instance.
        bus2.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus2.in_valid = 1'b1;
            bus2.in_data  = 64'(i);
            @(negedge clk);
            check_vec("n2_in_ready", 64'(bus2.in_ready), 64'd1);
            @(posedge clk); #1;
        end
        bus2.in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_vec("n2_valid", 64'(bus2.out_valid), 64'd1);
            check_vec("n2_data", bus2.out_data, 64'(tbl2[k]));
            check_vec("n2_last", 64'(bus2.out_last), 64'(k == 1));
        end
        @(negedge clk);
        check_vec("n2_done", 64'(bus2.out_valid), 64'd0);
        @(posedge clk); #1;

        // N=16 instance.
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus16.in_valid = 1'b1;
            bus16.in_data  = 64'(i);
            @(negedge clk);
            check_vec("n16_in_ready", 64'(bus16.in_ready), 64'd1);
            @(posedge clk); #1;
        end
        bus16.in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check_vec("n16_valid", 64'(bus16.out_valid), 64'd1);
            check_vec("n16_data", bus16.out_data, 64'(tbl16[k]));
            check_vec("n16_last", 64'(bus16.out_last), 64'(k == 15));
        end
        @(negedge clk);
        check_vec("n16_done", 64'(bus16.out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
